// File: rtl/ecc_155_err_monitor.sv
// ECC error monitor.
// Takes per-word flags from the ECC check stage and turns them into:
// saturating event counters, a first-error capture, and a level interrupt
// with a software acknowledge handshake.
// Stage 1 registers the incoming read and its flags. The event stage then
// updates the counters, the capture and the interrupt FSM from stage 1, so an
// event becomes visible two rising edges after it is sampled.
module ecc_155_err_monitor #(
  parameter int ADDR_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int SBIT_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  sbit_err,
  input  logic                  dbit_err,
  input  logic                  ecc_fault,
  input  logic                  clr,
  input  logic                  irq_ack,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  first_err_vld,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [1:0]            first_err_type,
  output logic                  irq
);

  // Interrupt FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Error type codes reported on first_err_type.
  localparam logic [1:0] TYPE_SBIT  = 2'b01;
  localparam logic [1:0] TYPE_DBIT  = 2'b10;
  localparam logic [1:0] TYPE_FAULT = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // The threshold can only be reached by an increment if it lies in
  // 1..CNT_MAX; otherwise the sbit trigger is never armed. Comparing the
  // counter against THRESH-1 before the increment means a saturated or
  // already-past-threshold counter can never fire again.
  localparam longint CNT_MAX_L   = (longint'(1) << CNT_WIDTH) - 1;
  localparam bit     THRESH_OK   = (SBIT_THRESH >= 1) &&
                                   (longint'(SBIT_THRESH) <= CNT_MAX_L);
  localparam logic [CNT_WIDTH-1:0] THRESH_PRE =
    THRESH_OK ? CNT_WIDTH'(SBIT_THRESH - 1) : '0;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v,
    input logic                 en
  );
    if (en && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end
    return v;
  endfunction

  // Stage 1 registers.
  logic                  r_vld_p1;
  logic [ADDR_WIDTH-1:0] r_addr_p1;
  logic                  r_sbit_p1;
  logic                  r_dbit_p1;
  logic                  r_fault_p1;

  // Event-stage state.
  logic [CNT_WIDTH-1:0]  r_sbit_cnt;
  logic [CNT_WIDTH-1:0]  r_dbit_cnt;
  logic [CNT_WIDTH-1:0]  r_fault_cnt;
  logic                  r_first_vld;
  logic [ADDR_WIDTH-1:0] r_first_addr;
  logic [1:0]            r_first_type;
  logic [1:0]            r_state;

  // Decoded stage-1 events.
  logic                  w_ev_sbit;
  logic                  w_ev_dbit;
  logic                  w_ev_fault;
  logic                  w_ev_any;
  logic                  w_ev_hard;
  logic                  w_sbit_hit;
  logic [1:0]            w_ev_type;
  logic [1:0]            w_state_nxt;

  // ---- stage 0 -> stage 1: register the checked read and its flags ----
  // Sample the read and its flags every cycle; only rst clears this stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_sbit_p1  <= 1'b0;
      r_dbit_p1  <= 1'b0;
      r_fault_p1 <= 1'b0;
    end else begin
      r_vld_p1   <= rd_vld;
      r_addr_p1  <= rd_addr;
      r_sbit_p1  <= sbit_err;
      r_dbit_p1  <= dbit_err;
      r_fault_p1 <= ecc_fault;
    end
  end

  // ---- stage 1 -> stage 2: classify, count, capture, interrupt ----
  // Classify the stage-1 word. A word flagged both sbit and dbit counts as
  // dbit only; a fault is independent of the sbit/dbit classification.
  always_comb begin
    w_ev_dbit  = r_vld_p1 & r_dbit_p1;
    w_ev_sbit  = r_vld_p1 & r_sbit_p1 & ~r_dbit_p1;
    w_ev_fault = r_vld_p1 & r_fault_p1;
    w_ev_any   = w_ev_sbit | w_ev_dbit | w_ev_fault;
    w_ev_hard  = w_ev_dbit | w_ev_fault;
    w_sbit_hit = THRESH_OK && w_ev_sbit && (r_sbit_cnt == THRESH_PRE);
    if (w_ev_fault) begin
      w_ev_type = TYPE_FAULT;
    end else if (w_ev_dbit) begin
      w_ev_type = TYPE_DBIT;
    end else begin
      w_ev_type = TYPE_SBIT;
    end
  end

  // Saturating event counters; clr discards the event of the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sbit_cnt  <= '0;
      r_dbit_cnt  <= '0;
      r_fault_cnt <= '0;
    end else begin
      r_sbit_cnt  <= sat_inc(r_sbit_cnt,  w_ev_sbit);
      r_dbit_cnt  <= sat_inc(r_dbit_cnt,  w_ev_dbit);
      r_fault_cnt <= sat_inc(r_fault_cnt, w_ev_fault);
    end
  end

  // Capture address and type of the first event; later events never overwrite.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_first_vld  <= 1'b0;
      r_first_addr <= '0;
      r_first_type <= '0;
    end else if (w_ev_any && !r_first_vld) begin
      r_first_vld  <= 1'b1;
      r_first_addr <= r_addr_p1;
      r_first_type <= w_ev_type;
    end
  end

  // Interrupt next state. In ASSERT a new trigger outranks a coincident ack;
  // from HOLD only dbit/fault events re-arm the interrupt.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ev_hard || w_sbit_hit) begin
            w_state_nxt = ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (!(w_ev_hard || w_sbit_hit) && irq_ack) begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_ev_hard) begin
            w_state_nxt = ST_ASSERT;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Interrupt state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign sbit_cnt       = r_sbit_cnt;
  assign dbit_cnt       = r_dbit_cnt;
  assign fault_cnt      = r_fault_cnt;
  assign first_err_vld  = r_first_vld;
  assign first_err_addr = r_first_addr;
  assign first_err_type = r_first_type;
  assign irq            = (r_state == ST_ASSERT);

endmodule
